// File: rtl/nf10_router_ingress_filter.sv
`default_nettype none
// ============================================================================
// Module   : nf10_router_ingress_filter
// Brief    : Buffers two header beats, decides DROP / TO_CPU / FORWARD, streams the rest.
// Revision : 1.0
// ============================================================================
module nf10_router_ingress_filter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int TABLE_DEPTH        = 32,
    parameter int SRC_PORT_POS       = 16,
    parameter int DST_PORT_POS       = 24,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                              AXI_ACLK,
    input  logic                              reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    input  logic [48*NUM_PORTS-1:0]           port_mac,
    input  logic                              clr_counters,
    input  logic                              tbl_wr_req,
    input  logic                              tbl_rd_req,
    input  logic [$clog2(TABLE_DEPTH)-1:0]    tbl_wr_addr,
    input  logic [$clog2(TABLE_DEPTH)-1:0]    tbl_rd_addr,
    input  logic [31:0]                       tbl_wr_data,
    output logic [31:0]                       tbl_rd_data,
    output logic                              tbl_wr_ack,
    output logic                              tbl_rd_ack,
    output logic [CNT_WIDTH-1:0]              pkt_in_count,
    output logic [CNT_WIDTH-1:0]              fwd_count,
    output logic [CNT_WIDTH-1:0]              cpu_count,
    output logic [CNT_WIDTH-1:0]              drop_csum_count,
    output logic [CNT_WIDTH-1:0]              drop_mac_count,
    output logic [CNT_WIDTH-1:0]              runt_count,
    output logic [CNT_WIDTH-1:0]              local_ip_count
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    localparam int CNT_PKT_IN = 0;
    localparam int CNT_FWD    = 1;
    localparam int CNT_CPU    = 2;
    localparam int CNT_CSUM   = 3;
    localparam int CNT_MAC    = 4;
    localparam int CNT_RUNT   = 5;
    localparam int CNT_LOCAL  = 6;
    localparam int NUM_CNT    = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_DECIDE, S_SEND0, S_SEND1, S_PASS, S_DROP_REST
    } state_t;

    typedef enum logic [1:0] {
        DEC_FWD, DEC_CPU, DEC_DROP_CSUM, DEC_DROP_MAC
    } dec_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
    logic [SW-1:0]      buf0_strb_q, buf0_strb_d, buf1_strb_q, buf1_strb_d;
    logic [UW-1:0]      buf0_user_q, buf0_user_d, buf1_user_q, buf1_user_d;
    logic               buf1_last_q, buf1_last_d;
    dec_t               dec_q, dec_d, dec_new;
    logic               hit_q, hit_d;
    logic [7:0]         cpu_dst_q, cpu_dst_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;
    logic [31:0]        tbl_mem [TABLE_DEPTH];
    logic [31:0]        tbl_rd_data_q, tbl_rd_data_d;
    logic               tbl_rd_ack_q, tbl_rd_ack_d, tbl_wr_ack_q, tbl_wr_ack_d;

    logic [47:0]        dst_mac;
    logic [15:0]        ethertype;
    logic [3:0]         version;
    logic [7:0]         ttl;
    logic [31:0]        dst_ip;
    logic [19:0]        csum_sum;
    logic [16:0]        csum_fold1;
    logic [15:0]        csum_fold2;
    logic [2:0]         src_cnt;
    logic               port_mac_hit, tbl_hit, is_ip, csum_ok, mac_ok, to_cpu;
    logic [7:0]         src_cpu_dst;

    function automatic logic [UW-1:0] f_rewrite(input logic [UW-1:0] user,
                                                input logic en, input logic [7:0] dst);
        f_rewrite = user;
        if (en) f_rewrite[DST_PORT_POS +: 8] = dst;
    endfunction

    // Header fields: beat 0 comes from buf0, beat 1 is the beat arriving in HDR1.
    assign dst_mac   = buf0_data_q[255:208];
    assign ethertype = buf0_data_q[159:144];
    assign version   = buf0_data_q[143:140];
    assign ttl       = buf0_data_q[79:72];
    assign dst_ip    = {buf0_data_q[15:0], S_AXIS_TDATA[255:240]};

    always_comb begin
        csum_sum = '0;
        for (int i = 0; i < 9; i++) csum_sum = csum_sum + 20'(buf0_data_q[16*i +: 16]);
        csum_sum   = csum_sum + 20'(S_AXIS_TDATA[255:240]);
        csum_fold1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
        csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);

        src_cnt      = '0;
        port_mac_hit = 1'b0;
        src_cpu_dst  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (buf0_user_q[SRC_PORT_POS + 2*k]) begin
                src_cnt     = src_cnt + 3'd1;
                src_cpu_dst = 8'(1 << (2*k + 1));
                if (dst_mac == port_mac[48*k +: 48]) port_mac_hit = 1'b1;
            end
        end

        tbl_hit = 1'b0;
        for (int i = 0; i < TABLE_DEPTH; i++)
            if (tbl_mem[i] != 32'd0 && tbl_mem[i] == dst_ip) tbl_hit = 1'b1;

        is_ip   = (ethertype == 16'h0800);
        csum_ok = (csum_fold2 == 16'hFFFF);
        mac_ok  = (src_cnt == 3'd1) && (dst_mac == 48'hFFFF_FFFF_FFFF || port_mac_hit);
        to_cpu  = (ttl <= 8'd1) || (version != 4'd4) || !is_ip || tbl_hit;

        if (is_ip && !csum_ok)  dec_new = DEC_DROP_CSUM;
        else if (!mac_ok)       dec_new = DEC_DROP_MAC;
        else if (to_cpu)        dec_new = DEC_CPU;
        else                    dec_new = DEC_FWD;
    end

    always_comb begin
        state_d     = state_q;
        buf0_data_d = buf0_data_q;
        buf0_strb_d = buf0_strb_q;
        buf0_user_d = buf0_user_q;
        buf1_data_d = buf1_data_q;
        buf1_strb_d = buf1_strb_q;
        buf1_user_d = buf1_user_q;
        buf1_last_d = buf1_last_q;
        dec_d       = dec_q;
        hit_d       = hit_q;
        cpu_dst_d   = cpu_dst_q;
        cnt_inc     = '0;
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TUSER  = '0;
        M_AXIS_TLAST  = 1'b0;

        case (state_q)
            S_IDLE: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID) begin
                    buf0_data_d = S_AXIS_TDATA;
                    buf0_strb_d = S_AXIS_TSTRB;
                    buf0_user_d = S_AXIS_TUSER;
                    cnt_inc[CNT_PKT_IN] = 1'b1;
                    if (S_AXIS_TLAST) cnt_inc[CNT_RUNT] = 1'b1;
                    else              state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID) begin
                    buf1_data_d = S_AXIS_TDATA;
                    buf1_strb_d = S_AXIS_TSTRB;
                    buf1_user_d = S_AXIS_TUSER;
                    buf1_last_d = S_AXIS_TLAST;
                    dec_d       = dec_new;
                    hit_d       = tbl_hit;
                    cpu_dst_d   = src_cpu_dst;
                    state_d     = S_DECIDE;
                end
            end
            S_DECIDE: begin
                case (dec_q)
                    DEC_FWD:       cnt_inc[CNT_FWD] = 1'b1;
                    DEC_CPU: begin
                        cnt_inc[CNT_CPU]   = 1'b1;
                        cnt_inc[CNT_LOCAL] = hit_q;
                    end
                    DEC_DROP_CSUM: cnt_inc[CNT_CSUM] = 1'b1;
                    default:       cnt_inc[CNT_MAC]  = 1'b1;
                endcase
                if (dec_q == DEC_DROP_CSUM || dec_q == DEC_DROP_MAC)
                    state_d = buf1_last_q ? S_IDLE : S_DROP_REST;
                else
                    state_d = S_SEND0;
            end
            S_SEND0: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = buf0_data_q;
                M_AXIS_TSTRB  = buf0_strb_q;
                M_AXIS_TUSER  = f_rewrite(buf0_user_q, dec_q == DEC_CPU, cpu_dst_q);
                if (M_AXIS_TREADY) state_d = S_SEND1;
            end
            S_SEND1: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = buf1_data_q;
                M_AXIS_TSTRB  = buf1_strb_q;
                M_AXIS_TUSER  = f_rewrite(buf1_user_q, dec_q == DEC_CPU, cpu_dst_q);
                M_AXIS_TLAST  = buf1_last_q;
                if (M_AXIS_TREADY) state_d = buf1_last_q ? S_IDLE : S_PASS;
            end
            S_PASS: begin
                S_AXIS_TREADY = M_AXIS_TREADY;
                M_AXIS_TVALID = S_AXIS_TVALID;
                M_AXIS_TDATA  = S_AXIS_TDATA;
                M_AXIS_TSTRB  = S_AXIS_TSTRB;
                M_AXIS_TUSER  = f_rewrite(S_AXIS_TUSER, dec_q == DEC_CPU, cpu_dst_q);
                M_AXIS_TLAST  = S_AXIS_TLAST;
                if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state_d = S_IDLE;
            end
            S_DROP_REST: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clear wins over any increment landing in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++)
            cnt_d[i] = clr_counters ? '0 : cnt_q[i] + CNT_WIDTH'(cnt_inc[i]);
        tbl_rd_data_d = tbl_rd_req ? tbl_mem[tbl_rd_addr] : tbl_rd_data_q;
        tbl_rd_ack_d  = tbl_rd_req;
        tbl_wr_ack_d  = tbl_wr_req;
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q       <= S_IDLE;
            buf0_data_q   <= '0;
            buf0_strb_q   <= '0;
            buf0_user_q   <= '0;
            buf1_data_q   <= '0;
            buf1_strb_q   <= '0;
            buf1_user_q   <= '0;
            buf1_last_q   <= 1'b0;
            dec_q         <= DEC_FWD;
            hit_q         <= 1'b0;
            cpu_dst_q     <= '0;
            tbl_rd_data_q <= '0;
            tbl_rd_ack_q  <= 1'b0;
            tbl_wr_ack_q  <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            buf0_data_q   <= buf0_data_d;
            buf0_strb_q   <= buf0_strb_d;
            buf0_user_q   <= buf0_user_d;
            buf1_data_q   <= buf1_data_d;
            buf1_strb_q   <= buf1_strb_d;
            buf1_user_q   <= buf1_user_d;
            buf1_last_q   <= buf1_last_d;
            dec_q         <= dec_d;
            hit_q         <= hit_d;
            cpu_dst_q     <= cpu_dst_d;
            tbl_rd_data_q <= tbl_rd_data_d;
            tbl_rd_ack_q  <= tbl_rd_ack_d;
            tbl_wr_ack_q  <= tbl_wr_ack_d;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Table contents survive reset; software owns them.
    always_ff @(posedge AXI_ACLK) begin
        if (tbl_wr_req) tbl_mem[tbl_wr_addr] <= tbl_wr_data;
    end

    assign tbl_rd_data     = tbl_rd_data_q;
    assign tbl_rd_ack      = tbl_rd_ack_q;
    assign tbl_wr_ack      = tbl_wr_ack_q;
    assign pkt_in_count    = cnt_q[CNT_PKT_IN];
    assign fwd_count       = cnt_q[CNT_FWD];
    assign cpu_count       = cnt_q[CNT_CPU];
    assign drop_csum_count = cnt_q[CNT_CSUM];
    assign drop_mac_count  = cnt_q[CNT_MAC];
    assign runt_count      = cnt_q[CNT_RUNT];
    assign local_ip_count  = cnt_q[CNT_LOCAL];

endmodule
`default_nettype wire
